// File: rtl/jts16_pcm_multi.sv
// Multi-channel PCM playback engine: each sample tick scans all channels, fetches
// one ROM byte per active channel, scales it by volume and mixes into one output.
module jts16_pcm_multi #(
    parameter int CH = 4,
    parameter int AW = 17,
    parameter int FW = 4,
    parameter int VW = 4,
    parameter int OW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen_smp,
    input  logic [$clog2(CH)-1:0] reg_ch,
    input  logic [2:0]            reg_sel,
    input  logic [AW-1:0]         reg_din,
    input  logic                  reg_we,
    output logic [AW-1:0]         pcm_addr,
    output logic                  pcm_cs,
    input  logic [7:0]            pcm_data,
    input  logic                  pcm_ok,
    output logic [CH-1:0]         ch_busy,
    output logic signed [OW-1:0]  snd,
    output logic                  snd_upd
);
    localparam int CW    = $clog2(CH);
    localparam int PW    = 8 + VW + 1;
    localparam int ACC_W = PW + CW;
    localparam int PSW   = AW + FW;

    typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, ACC, OUT} state_t;

    state_t                   st;
    logic [AW-1:0]            start_r [CH];
    logic [AW-1:0]            end_r   [CH];
    logic [AW-1:0]            loop_r  [CH];
    logic [7:0]               step_r  [CH];
    logic [VW-1:0]            vol_r   [CH];
    logic [PSW-1:0]           pos_r   [CH];
    logic [CH-1:0]            loop_en;
    logic [CW-1:0]            ch_idx;
    logic [7:0]               data_p1;
    logic                     rekey;
    logic signed [ACC_W-1:0]  acc;

    logic signed [7:0]        smp;
    logic signed [PW-1:0]     prod;
    logic [PSW-1:0]           pos_nx;
    logic                     past_end;
    logic                     key_cur;
    logic                     last_ch;

    function automatic logic signed [OW-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        longint v, hi, lo;
        v  = longint'(a);
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return OW'(hi);
        if (v < lo) return OW'(lo);
        return OW'(v);
    endfunction

    always_comb begin
        smp      = $signed({~data_p1[7], data_p1[6:0]});
        prod     = PW'(smp) * PW'($signed({1'b0, vol_r[ch_idx]}));
        pos_nx   = pos_r[ch_idx] + PSW'(step_r[ch_idx]);
        // a zero step never advances, so it must never trip the end check
        past_end = (step_r[ch_idx] != 8'd0) && (pos_nx[PSW-1:FW] > end_r[ch_idx]);
        key_cur  = reg_we && (reg_sel == 3'd5) && (reg_ch == ch_idx);
        last_ch  = (ch_idx == CW'(CH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            ch_idx   <= '0;
            pcm_cs   <= 1'b0;
            pcm_addr <= '0;
            snd      <= '0;
            snd_upd  <= 1'b0;
            acc      <= '0;
            data_p1  <= '0;
            rekey    <= 1'b0;
            ch_busy  <= '0;
            loop_en  <= '0;
            for (int i = 0; i < CH; i++) begin
                start_r[i] <= '0;
                end_r[i]   <= '0;
                loop_r[i]  <= '0;
                step_r[i]  <= '0;
                vol_r[i]   <= '0;
                pos_r[i]   <= '0;
            end
        end else begin
            snd_upd <= 1'b0;
            case (st)
                IDLE: if (cen_smp) begin
                    st     <= SCAN;
                    ch_idx <= '0;
                end
                SCAN: begin
                    rekey <= key_cur;
                    if (ch_busy[ch_idx]) begin
                        st       <= REQ;
                        pcm_cs   <= 1'b1;
                        pcm_addr <= pos_r[ch_idx][PSW-1:FW];
                    end else if (last_ch) begin
                        st <= OUT;
                    end else begin
                        ch_idx <= ch_idx + CW'(1);
                    end
                end
                REQ: begin
                    rekey <= rekey | key_cur;
                    st    <= WAIT;
                end
                // ROM handshake: address and request held until data arrives
                WAIT: begin
                    rekey <= rekey | key_cur;
                    if (pcm_ok) begin
                        data_p1 <= pcm_data;
                        pcm_cs  <= 1'b0;
                        st      <= ACC;
                    end
                end
                // mix stage: sample contributes even if the channel was re-keyed meanwhile
                ACC: begin
                    acc   <= acc + ACC_W'(prod);
                    rekey <= 1'b0;
                    if (!rekey) begin
                        if (past_end && loop_en[ch_idx])
                            pos_r[ch_idx] <= PSW'(loop_r[ch_idx]) << FW;
                        else if (past_end)
                            ch_busy[ch_idx] <= 1'b0;
                        else
                            pos_r[ch_idx] <= pos_nx;
                    end
                    if (last_ch) begin
                        st <= OUT;
                    end else begin
                        st     <= SCAN;
                        ch_idx <= ch_idx + CW'(1);
                    end
                end
                OUT: begin
                    snd     <= sat_out(acc);
                    snd_upd <= 1'b1;
                    acc     <= '0;
                    st      <= IDLE;
                end
                default: st <= IDLE;
            endcase

            // register port last, so key writes override the scan's own updates
            if (reg_we) begin
                case (reg_sel)
                    3'd0: start_r[reg_ch] <= reg_din;
                    3'd1: end_r[reg_ch]   <= reg_din;
                    3'd2: loop_r[reg_ch]  <= reg_din;
                    3'd3: step_r[reg_ch]  <= reg_din[7:0];
                    3'd4: begin
                        vol_r[reg_ch]   <= reg_din[VW-1:0];
                        loop_en[reg_ch] <= reg_din[VW];
                    end
                    3'd5: begin
                        if (reg_din[0]) begin
                            pos_r[reg_ch]   <= PSW'(start_r[reg_ch]) << FW;
                            ch_busy[reg_ch] <= 1'b1;
                        end else begin
                            ch_busy[reg_ch] <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
